fixed_to_float_rne: RTL and testbench

Pipelined, parametrised converter from a signed or unsigned fixed-point word to an IEEE-754 single-precision float. It adds several features over the fixed 32-bit integer converter:

- configurable input width and fractional-bit position
- a per-sample signed/unsigned mode
- round-to-nearest-even with an inexact flag
- a correctly encoded +0
- valid/ready flow control

It sits between fixed-point DSP datapaths and float consumers on a streaming interface.

---
 rtl/fixed_to_float_rne_pkg.sv | 35 +++
 rtl/fixed_to_float_norm.sv | 40 ++++
 rtl/fixed_to_float_rne.sv | 161 ++++++++++++++++
 tb/tb_fixed_to_float_rne.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fixed_to_float_rne_pkg.sv
// Shared constants and helpers for the fixed-point to IEEE-754 single converter.
package fixed_to_float_rne_pkg;

    localparam int lp_BIAS        = 127;
    localparam int lp_EXP_WIDTH   = 8;
    localparam int lp_MAN_WIDTH   = 23;
    localparam int lp_FLOAT_WIDTH = 1 + lp_EXP_WIDTH + lp_MAN_WIDTH;

    // Field positions inside the packed single-precision word
    localparam int lp_SIGN_POS = lp_FLOAT_WIDTH - 1;
    localparam int lp_EXP_MSB  = lp_FLOAT_WIDTH - 2;
    localparam int lp_EXP_LSB  = lp_MAN_WIDTH;
    localparam int lp_MAN_MSB  = lp_MAN_WIDTH - 1;
    localparam int lp_MAN_LSB  = 0;

    // Width of a leading-zero count able to hold 0..width-1
    function automatic int f_clz_width(input int width);
        return $clog2(width);
    endfunction

    // Assemble {sign, exponent, mantissa} into a float word
    function automatic logic [lp_FLOAT_WIDTH-1:0] f_pack(
        input logic                    sign,
        input logic [lp_EXP_WIDTH-1:0] exponent,
        input logic [lp_MAN_WIDTH-1:0] mantissa
    );
        logic [lp_FLOAT_WIDTH-1:0] w_word;
        w_word                         = '0;
        w_word[lp_SIGN_POS]            = sign;
        w_word[lp_EXP_MSB:lp_EXP_LSB]  = exponent;
        w_word[lp_MAN_MSB:lp_MAN_LSB]  = mantissa;
        return w_word;
    endfunction

endpackage

// File: rtl/fixed_to_float_norm.sv
// Combinational normaliser: counts leading zeros of a magnitude and shifts
// it left so the most significant set bit lands in the MSB.
module fixed_to_float_norm
    import fixed_to_float_rne_pkg::*;
#(
    parameter int p_WIDTH = 32
) (
    input  logic [p_WIDTH-1:0]              i_MAG,
    output logic [p_WIDTH-1:0]              o_NORM,
    output logic [f_clz_width(p_WIDTH)-1:0] o_LZC,
    output logic                            o_ALL_ZERO
);

    localparam int lp_ZW = f_clz_width(p_WIDTH);

    logic [p_WIDTH-1:0] w_shift;
    logic [lp_ZW-1:0]   w_lzc;

    // Logarithmic shifter: each step removes 2^k leading zeros if present,
    // and that decision is bit k of the count. Since 2^(lp_ZW-1) < p_WIDTH
    // every step inspects a real slice of the word.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs; no latch.
        w_shift = i_MAG;
        w_lzc   = '0;
        for (int k = lp_ZW - 1; k >= 0; k--) begin
            // NOTE: blocking assignments are deliberate here: w_shift is a
            // running combinational value refined step by step, not state.
            if ((w_shift >> (p_WIDTH - (1 << k))) == '0) begin
                w_shift  = w_shift << (1 << k);
                w_lzc[k] = 1'b1;
            end
        end
    end

    assign o_NORM     = w_shift;
    assign o_LZC      = w_lzc;
    assign o_ALL_ZERO = (i_MAG == '0);

endmodule

// File: rtl/fixed_to_float_rne.sv
// Three-stage fixed-point to IEEE-754 single converter with round-to-nearest-
// even, inexact/zero flags and a global valid/ready stall.
//   S0: sign and magnitude   S1: normalise, exponent   S2: round and pack
module fixed_to_float_rne
    import fixed_to_float_rne_pkg::*;
#(
    parameter int p_IN_WIDTH  = 32,
    parameter int p_FRAC_BITS = 0
) (
    input  logic                      i_CLK,
    input  logic                      i_RST,
    input  logic                      i_VALID,
    output logic                      o_READY,
    input  logic [p_IN_WIDTH-1:0]     i_FIXED_WORD,
    input  logic                      i_SIGNED,
    output logic                      o_VALID,
    input  logic                      i_READY,
    output logic [lp_FLOAT_WIDTH-1:0] o_FLOAT_WORD,
    output logic                      o_INEXACT,
    output logic                      o_ZERO
);

    localparam int lp_ZW       = f_clz_width(p_IN_WIDTH);
    // Exponent of a word whose MSB is set; each leading zero lowers it by one
    localparam int lp_EXP_BASE = lp_BIAS + p_IN_WIDTH - 1 - p_FRAC_BITS;
    // Narrow inputs are zero-padded so mantissa, guard and sticky always exist
    localparam int lp_EXT_W    = (p_IN_WIDTH < lp_MAN_WIDTH + 3) ? lp_MAN_WIDTH + 3 : p_IN_WIDTH;
    localparam int lp_SIG_W    = lp_MAN_WIDTH + 1;

    // ------------------------------------------------------------------
    // Flow control
    // ------------------------------------------------------------------
    logic w_advance;
    logic r_s0_valid;
    logic r_s1_valid;
    logic r_s2_valid;

    assign w_advance = ~r_s2_valid | i_READY;
    assign o_READY   = w_advance;
    assign o_VALID   = r_s2_valid;

    // Stage-valid shift register; bubbles move with the data on advance
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            r_s0_valid <= 1'b0;
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else if (w_advance) begin
            r_s0_valid <= i_VALID;
            r_s1_valid <= r_s0_valid;
            r_s2_valid <= r_s1_valid;
        end
    end

    // ------------------------------------------------------------------
    // S0: sign and magnitude
    // ------------------------------------------------------------------
    logic                  w_in_neg;
    logic [p_IN_WIDTH-1:0] w_in_mag;
    logic                  r_s0_sign;
    logic [p_IN_WIDTH-1:0] r_s0_mag;

    // Two's complement negate is taken as unsigned, so -2^(W-1) maps to 2^(W-1)
    assign w_in_neg = i_SIGNED & i_FIXED_WORD[p_IN_WIDTH-1];
    assign w_in_mag = w_in_neg ? (~i_FIXED_WORD + p_IN_WIDTH'(1)) : i_FIXED_WORD;

    // ------------------------------------------------------------------
    // S1: normalise and exponent
    // ------------------------------------------------------------------
    logic [p_IN_WIDTH-1:0]   w_norm;
    logic [lp_ZW-1:0]        w_lzc;
    logic                    w_all_zero;
    logic                    r_s1_sign;
    logic                    r_s1_zero;
    logic [p_IN_WIDTH-1:0]   r_s1_norm;
    logic [lp_EXP_WIDTH-1:0] r_s1_exp;

    fixed_to_float_norm #(
        .p_WIDTH    (p_IN_WIDTH)
    ) u_norm (
        .i_MAG      (r_s0_mag),
        .o_NORM     (w_norm),
        .o_LZC      (w_lzc),
        .o_ALL_ZERO (w_all_zero)
    );

    // Pipeline data registers for S0 and S1, loaded whenever the pipe moves
    // NOTE: these carry no reset; a stale value is harmless because the
    // matching valid bit is cleared, and skipping reset keeps the flops lean.
    always_ff @(posedge i_CLK) begin
        if (w_advance) begin
            r_s0_sign <= w_in_neg;
            r_s0_mag  <= w_in_mag;
            r_s1_sign <= r_s0_sign;
            r_s1_zero <= w_all_zero;
            r_s1_norm <= w_norm;
            r_s1_exp  <= lp_EXP_WIDTH'(lp_EXP_BASE - int'(w_lzc));
        end
    end

    // ------------------------------------------------------------------
    // S2: round to nearest even, handle carry, pack
    // ------------------------------------------------------------------
    logic [lp_EXT_W-1:0]       w_ext;
    logic [lp_SIG_W-1:0]       w_sig;
    logic                      w_guard;
    logic                      w_sticky;
    logic                      w_round_up;
    logic [lp_SIG_W:0]         w_sum;
    logic                      w_carry;
    logic [lp_EXP_WIDTH-1:0]   w_exp_rnd;
    logic [lp_FLOAT_WIDTH-1:0] w_pack;
    logic [lp_FLOAT_WIDTH-1:0] w_res_word;
    logic                      w_res_inexact;

    // Left-align the normalised word; the hidden bit sits at the top of w_sig
    assign w_ext      = lp_EXT_W'(r_s1_norm) << (lp_EXT_W - p_IN_WIDTH);
    assign w_sig      = w_ext[lp_EXT_W-1 -: lp_SIG_W];
    assign w_guard    = w_ext[lp_EXT_W-lp_SIG_W-1];
    assign w_sticky   = |w_ext[lp_EXT_W-lp_SIG_W-2:0];
    assign w_round_up = w_guard & (w_sticky | w_sig[0]);

    // Rounding an all-ones significand yields 10.00..0: the mantissa wraps to
    // zero and the exponent absorbs the carry
    assign w_sum      = {1'b0, w_sig} + (lp_SIG_W + 1)'(w_round_up);
    assign w_carry    = w_sum[lp_SIG_W] & ~w_sum[lp_SIG_W-1];
    assign w_exp_rnd  = r_s1_exp + lp_EXP_WIDTH'(w_carry);
    assign w_pack     = f_pack(r_s1_sign, w_exp_rnd, w_sum[lp_MAN_WIDTH-1:0]);

    // Zero input bypasses the packer so it always encodes as +0 and exact
    always_comb begin
        w_res_word    = w_pack;
        w_res_inexact = w_guard | w_sticky;
        if (r_s1_zero) begin
            w_res_word    = '0;
            w_res_inexact = 1'b0;
        end
    end

    logic [lp_FLOAT_WIDTH-1:0] r_out_word;
    logic                      r_out_inexact;
    logic                      r_out_zero;

    // Output registers: cleared on reset, otherwise held unless the pipe moves
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            r_out_word    <= '0;
            r_out_inexact <= 1'b0;
            r_out_zero    <= 1'b0;
        end else if (w_advance) begin
            r_out_word    <= w_res_word;
            r_out_inexact <= w_res_inexact;
            r_out_zero    <= r_s1_zero;
        end
    end

    assign o_FLOAT_WORD = r_out_word;
    assign o_INEXACT    = r_out_inexact;
    assign o_ZERO       = r_out_zero;

endmodule

// File: tb/tb_fixed_to_float_rne.sv
// Scoreboard bench for fixed_to_float_rne: three instances (default, 16
// fractional bits, 16-bit input), a reference model built from plain integer
// arithmetic, and monitors that pop expectations whenever an output transfers.
module tb_fixed_to_float_rne;

    typedef struct packed {
        logic [31:0] word;
        logic        inexact;
        logic        zero;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance A: default parameters
    logic        a_valid, a_ready, a_sgn, a_ovalid, a_iready, a_inexact, a_zero;
    logic [31:0] a_word, a_float;
    // Instance F: 16 fractional bits
    logic        f_valid, f_ready, f_sgn, f_ovalid, f_iready, f_inexact, f_zero;
    logic [31:0] f_word, f_float;
    // Instance N: 16-bit input
    logic        n_valid, n_ready, n_sgn, n_ovalid, n_iready, n_inexact, n_zero;
    logic [15:0] n_word;
    logic [31:0] n_float;

    fixed_to_float_rne dut_a (
        .i_CLK (clk), .i_RST (rst), .i_VALID (a_valid), .o_READY (a_ready),
        .i_FIXED_WORD (a_word), .i_SIGNED (a_sgn), .o_VALID (a_ovalid),
        .i_READY (a_iready), .o_FLOAT_WORD (a_float), .o_INEXACT (a_inexact),
        .o_ZERO (a_zero)
    );

    fixed_to_float_rne #(.p_IN_WIDTH (32), .p_FRAC_BITS (16)) dut_f (
        .i_CLK (clk), .i_RST (rst), .i_VALID (f_valid), .o_READY (f_ready),
        .i_FIXED_WORD (f_word), .i_SIGNED (f_sgn), .o_VALID (f_ovalid),
        .i_READY (f_iready), .o_FLOAT_WORD (f_float), .o_INEXACT (f_inexact),
        .o_ZERO (f_zero)
    );

    fixed_to_float_rne #(.p_IN_WIDTH (16), .p_FRAC_BITS (0)) dut_n (
        .i_CLK (clk), .i_RST (rst), .i_VALID (n_valid), .o_READY (n_ready),
        .i_FIXED_WORD (n_word), .i_SIGNED (n_sgn), .o_VALID (n_ovalid),
        .i_READY (n_iready), .o_FLOAT_WORD (n_float), .o_INEXACT (n_inexact),
        .o_ZERO (n_zero)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t q_a[$];
    exp_t q_f[$];
    exp_t q_n[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic flag(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    function automatic exp_t mk(input logic [31:0] word, input logic inexact, input logic zero);
        exp_t e;
        e.word    = word;
        e.inexact = inexact;
        e.zero    = zero;
        return e;
    endfunction

    // Reference: value = M * 2^-f; find the top set bit, keep 24 significant
    // bits, and round the discarded remainder against exactly one half.
    function automatic exp_t ref_convert(input logic [63:0] raw, input int w, input int f, input bit sgn);
        logic [63:0] x, m, q, rem, half;
        bit          neg;
        bit          inexact;
        int          e, sh;
        x   = raw & ((64'd1 << w) - 64'd1);
        neg = sgn && x[w-1];
        m   = neg ? ((64'd1 << w) - x) : x;
        if (m == 64'd0) return mk(32'h0, 1'b0, 1'b1);
        e = 63;
        while (e > 0 && !m[e]) e--;
        if (e <= 23) begin
            q       = m << (23 - e);
            inexact = 1'b0;
        end else begin
            sh      = e - 23;
            q       = m >> sh;
            rem     = m - (q << sh);
            half    = 64'd1 << (sh - 1);
            inexact = (rem != 64'd0);
            if (rem > half || (rem == half && q[0])) q = q + 64'd1;
            if (q == (64'd1 << 24)) begin
                q = q >> 1;
                e++;
            end
        end
        return mk({neg, 8'(127 + e - f), q[22:0]}, inexact, 1'b0);
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] v;
        case ($urandom_range(0, 4))
            0:       v = $urandom;
            1:       v = 32'($urandom_range(0, 255));
            2:       v = 32'h1 << $urandom_range(0, 31);
            3:       v = -32'($urandom_range(1, 1000));
            default: v = ($urandom & 32'hFFFF_FF00) | 32'h80;
        endcase
        return v;
    endfunction

    // Offer one word to A; push its expectation on the edge that accepts it
    task automatic send_a(input logic [31:0] w, input bit s, input exp_t e);
        bit acc;
        int n;
        a_valid = 1'b1;
        a_word  = w;
        a_sgn   = s;
        acc     = 1'b0;
        n       = 0;
        while (!acc && n < 1000) begin
            @(negedge clk);
            acc = a_ready;
            @(posedge clk);
            #1;
            n++;
        end
        a_valid = 1'b0;
        if (acc) q_a.push_back(e);
        else flag("accept_timeout_a");
    endtask

    task automatic send_f(input logic [31:0] w, input bit s, input exp_t e);
        bit acc;
        f_valid = 1'b1;
        f_word  = w;
        f_sgn   = s;
        @(negedge clk);
        acc = f_ready;
        @(posedge clk);
        #1;
        f_valid = 1'b0;
        check("accept_f", acc, 1);
        if (acc) q_f.push_back(e);
    endtask

    task automatic send_n(input logic [15:0] w, input bit s, input exp_t e);
        bit acc;
        n_valid = 1'b1;
        n_word  = w;
        n_sgn   = s;
        @(negedge clk);
        acc = n_ready;
        @(posedge clk);
        #1;
        n_valid = 1'b0;
        check("accept_n", acc, 1);
        if (acc) q_n.push_back(e);
    endtask

    task automatic drain_all();
        int n;
        n = 0;
        while ((q_a.size() + q_f.size() + q_n.size()) != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_a", q_a.size(), 0);
        check("drain_f", q_f.size(), 0);
        check("drain_n", q_n.size(), 0);
    endtask

    // Monitor A: compare on every transfer, and require stalled outputs to hold
    initial begin : mon_a
        exp_t        e;
        bit          pend;
        logic [33:0] held;
        pend = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    check("hold_valid", a_ovalid, 1);
                    check("hold_data", {a_float, a_inexact, a_zero}, held);
                end
                if (a_ovalid && a_iready) begin
                    if (q_a.size() == 0) begin
                        flag("unexpected_output_a");
                    end else begin
                        e = q_a.pop_front();
                        check("word_a", a_float, e.word);
                        check("inexact_a", a_inexact, e.inexact);
                        check("zero_a", a_zero, e.zero);
                    end
                end
                pend = a_ovalid && !a_iready;
                held = {a_float, a_inexact, a_zero};
            end
        end
    end

    initial begin : mon_f
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && f_ovalid) begin
                if (q_f.size() == 0) begin
                    flag("unexpected_output_f");
                end else begin
                    e = q_f.pop_front();
                    check("word_f", f_float, e.word);
                    check("inexact_f", f_inexact, e.inexact);
                    check("zero_f", f_zero, e.zero);
                end
            end
        end
    end

    initial begin : mon_n
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && n_ovalid) begin
                if (q_n.size() == 0) begin
                    flag("unexpected_output_n");
                end else begin
                    e = q_n.pop_front();
                    check("word_n", n_float, e.word);
                    check("inexact_n", n_inexact, e.inexact);
                    check("zero_n", n_zero, e.zero);
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bit          rnd_done;
        logic [31:0] w;
        bit          s;

        rst = 1'b1;
        a_valid = 1'b0; a_word = '0; a_sgn = 1'b0; a_iready = 1'b1;
        f_valid = 1'b0; f_word = '0; f_sgn = 1'b0; f_iready = 1'b1;
        n_valid = 1'b0; n_word = '0; n_sgn = 1'b0; n_iready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        check("rst_valid", a_ovalid, 0);
        check("rst_word", a_float, 0);
        check("rst_inexact", a_inexact, 0);
        check("rst_zero", a_zero, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_rst", a_ready, 1);

        // Latency: o_VALID rises on the third edge counting the accepting one
        send_a(32'h0000_0001, 1'b1, mk(32'h3F80_0000, 1'b0, 1'b0));
        check("lat_edge1", a_ovalid, 0);
        @(posedge clk); #1;
        check("lat_edge2", a_ovalid, 0);
        @(posedge clk); #1;
        check("lat_edge3", a_ovalid, 1);
        drain_all();

        // Directed values, back to back
        send_a(32'hFFFF_FFFF, 1'b1, mk(32'hBF80_0000, 1'b0, 1'b0));
        send_a(32'h8000_0000, 1'b1, mk(32'hCF00_0000, 1'b0, 1'b0));
        send_a(32'hFFFF_FFFF, 1'b0, mk(32'h4F80_0000, 1'b1, 1'b0));
        send_a(32'h0000_0000, 1'b0, mk(32'h0000_0000, 1'b0, 1'b1));
        send_a(32'h0000_0000, 1'b1, mk(32'h0000_0000, 1'b0, 1'b1));
        send_a(32'h0100_0001, 1'b0, mk(32'h4B80_0000, 1'b1, 1'b0));
        send_a(32'h0100_0003, 1'b0, mk(32'h4B80_0002, 1'b1, 1'b0));
        send_a(32'h8000_0000, 1'b0, mk(32'h4F00_0000, 1'b0, 1'b0));
        drain_all();

        // Backpressure: stream 1..10 with downstream stalled for 5 cycles
        fork
            begin
                for (int i = 1; i <= 10; i++)
                    send_a(32'(i), 1'b1, ref_convert(64'(i), 32, 0, 1'b1));
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                a_iready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                a_iready = 1'b1;
            end
        join
        drain_all();

        // Randomised traffic with random downstream readiness and input gaps
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    w = rand_word();
                    s = 1'($urandom_range(0, 1));
                    send_a(w, s, ref_convert(64'(w), 32, 0, s));
                    if ($urandom_range(0, 4) == 0) begin
                        repeat ($urandom_range(1, 3)) @(posedge clk);
                        #1;
                    end
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    a_iready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        a_iready = 1'b1;
        drain_all();

        // Reset with three words in flight (first one stalled at the output)
        a_iready = 1'b0;
        send_a(32'h0000_0011, 1'b0, ref_convert(64'h11, 32, 0, 1'b0));
        send_a(32'h0000_0022, 1'b0, ref_convert(64'h22, 32, 0, 1'b0));
        send_a(32'h0000_0033, 1'b0, ref_convert(64'h33, 32, 0, 1'b0));
        check("stalled_before_rst", a_ovalid, 1);
        rst     = 1'b1;
        a_valid = 1'b1;
        a_word  = 32'h1234_5678;
        a_sgn   = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_valid", a_ovalid, 0);
        check("rst_mid_word", a_float, 0);
        check("rst_mid_inexact", a_inexact, 0);
        check("rst_mid_zero", a_zero, 0);
        @(posedge clk); #1;
        rst      = 1'b0;
        a_valid  = 1'b0;
        a_iready = 1'b1;
        q_a.delete();
        check("ready_after_mid_rst", a_ready, 1);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check("rst_flush_valid", a_ovalid, 0);
        end

        // 16 fractional bits
        send_f(32'h0001_8000, 1'b1, mk(32'h3FC0_0000, 1'b0, 1'b0));
        send_f(32'hFFFF_8000, 1'b1, mk(32'hBF00_0000, 1'b0, 1'b0));
        for (int i = 0; i < 40; i++) begin
            w = rand_word();
            s = 1'($urandom_range(0, 1));
            send_f(w, s, ref_convert(64'(w), 32, 16, s));
        end

        // 16-bit input: always exact
        send_n(16'h7FFF, 1'b1, mk(32'h46FF_FE00, 1'b0, 1'b0));
        send_n(16'h8000, 1'b1, mk(32'hC700_0000, 1'b0, 1'b0));
        send_n(16'h0000, 1'b1, mk(32'h0000_0000, 1'b0, 1'b1));
        for (int i = 0; i < 40; i++) begin
            w = $urandom;
            s = 1'($urandom_range(0, 1));
            send_n(w[15:0], s, ref_convert(64'(w[15:0]), 16, 0, s));
        end
        drain_all();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
